csr_bus_master: RTL and testbench

- Initiator side of the CSR bus: turns single host commands (CSR write, CSR read) into handshaked transactions toward the accelerator CSR block.
- Returns one response per command.
- Sits between the host/testbench command port and the CSR slave; one transaction outstanding at a time.
- Handles the slave's registered read data (valid one cycle after handshake) and a ready timeout.

---
 rtl/csr_bus_master.sv | 218 +++++++++++++++++++++
 tb/tb_csr_bus_master.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/csr_bus_master.sv
// csr_bus_master
//   Initiator side of the CSR bus. Converts single host commands (CSR write,
//   CSR read) into valid/ready transactions toward the accelerator CSR block
//   and returns exactly one response per command. One transaction is
//   outstanding at a time. Read data from the slave is registered, so it is
//   captured one cycle after the handshake. A ready timeout turns a stalled
//   request into an error response.
//
//   Optional feature (define CSR_MASTER_POLL_EN): a read of MAIN (idx 0) with
//   cmd_poll=1 is re-issued every POLL_GAP idle cycles while bit 27 (busy)
//   of the returned value is set; the response carries the final value.
//   Without the macro cmd_poll is ignored and no POLL_WAIT state exists.
//
// Parameters
//   CSR_BASE_ADDR   base address; low 4 bits are replaced by cmd_idx
//   TIMEOUT_CYCLES  max REQ cycles waiting for bus_ready (0 = no timeout)
//   POLL_GAP        idle cycles between poll reads (poll feature only)
//
// Ports
//   clk, rst                       clock (rising edge), async active-high reset
//   cmd_valid/cmd_ready            command handshake
//   cmd_write, cmd_idx, cmd_wdata  command contents
//   cmd_poll                       poll MAIN until not busy (poll feature only)
//   rsp_valid/rsp_ready            response handshake
//   rsp_rdata, rsp_err             read data (0 for writes/errors), timeout flag
//   bus_valid/bus_ready            CSR bus handshake
//   bus_wen, bus_addr, bus_wdata   CSR bus request
//   bus_rdata                      CSR bus read data (registered by slave)
module csr_bus_master #(
    parameter logic [31:0] CSR_BASE_ADDR  = 32'h0000_0010,
    parameter int unsigned TIMEOUT_CYCLES = 256,
    parameter int unsigned POLL_GAP       = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [3:0]  cmd_idx,
    input  logic [31:0] cmd_wdata,
    input  logic        cmd_poll,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        bus_valid,
    input  logic        bus_ready,
    output logic        bus_wen,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata
);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        RCAP,
        RSP
`ifdef CSR_MASTER_POLL_EN
        ,
        POLL_WAIT
`endif
    } state_t;

    state_t      state_q, state_d;
    logic        cmd_ready_d;
    logic        bus_valid_d, bus_wen_d;
    logic [31:0] bus_addr_d, bus_wdata_d;
    logic [31:0] rsp_rdata_d;
    logic        rsp_err_d;
    logic [31:0] tcnt_q, tcnt_d;
    logic        timeout_hit;

`ifdef CSR_MASTER_POLL_EN
    logic        poll_q, poll_d;
    logic [31:0] gap_q, gap_d;
`else
    logic        unused_poll;
    assign unused_poll = cmd_poll | (POLL_GAP == 0);
`endif

    // The count reaching the limit only matters when no ready arrived this
    // cycle; the REQ branch checks bus_ready first so the handshake wins.
    assign timeout_hit = (TIMEOUT_CYCLES != 0) &&
                         ((tcnt_q + 32'd1) == TIMEOUT_CYCLES);

    assign rsp_valid = (state_q == RSP);

    always_comb begin
        state_d     = state_q;
        bus_valid_d = bus_valid;
        bus_wen_d   = bus_wen;
        bus_addr_d  = bus_addr;
        bus_wdata_d = bus_wdata;
        rsp_rdata_d = rsp_rdata;
        rsp_err_d   = rsp_err;
        tcnt_d      = tcnt_q;
`ifdef CSR_MASTER_POLL_EN
        poll_d      = poll_q;
        gap_d       = gap_q;
`endif

        case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    bus_valid_d = 1'b1;
                    bus_wen_d   = cmd_write;
                    bus_addr_d  = {CSR_BASE_ADDR[31:4], cmd_idx};
                    bus_wdata_d = cmd_wdata;
                    tcnt_d      = '0;
                    state_d     = REQ;
`ifdef CSR_MASTER_POLL_EN
                    poll_d      = cmd_poll && !cmd_write && (cmd_idx == 4'd0);
`endif
                end
            end

            REQ: begin
                if (bus_ready) begin
                    bus_valid_d = 1'b0;
                    if (bus_wen) begin
                        rsp_rdata_d = '0;
                        rsp_err_d   = 1'b0;
                        state_d     = RSP;
                    end else begin
                        state_d     = RCAP;
                    end
                end else if (timeout_hit) begin
                    bus_valid_d = 1'b0;
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b1;
                    state_d     = RSP;
                end else begin
                    tcnt_d      = tcnt_q + 32'd1;
                end
            end

            RCAP: begin
                rsp_rdata_d = bus_rdata;
                rsp_err_d   = 1'b0;
                state_d     = RSP;
`ifdef CSR_MASTER_POLL_EN
                if (poll_q && bus_rdata[27]) begin
                    if (POLL_GAP == 0) begin
                        bus_valid_d = 1'b1;
                        tcnt_d      = '0;
                        state_d     = REQ;
                    end else begin
                        gap_d       = '0;
                        state_d     = POLL_WAIT;
                    end
                end
`endif
            end

            RSP: begin
                if (rsp_ready) begin
                    rsp_err_d = 1'b0;
                    state_d   = IDLE;
                end
            end

`ifdef CSR_MASTER_POLL_EN
            POLL_WAIT: begin
                if (gap_q == (POLL_GAP - 1)) begin
                    bus_valid_d = 1'b1;
                    tcnt_d      = '0;
                    state_d     = REQ;
                end else begin
                    gap_d       = gap_q + 32'd1;
                end
            end
`endif

            default: begin
                state_d     = IDLE;
                bus_valid_d = 1'b0;
            end
        endcase

        // Registered so that it is low during reset and only rises the cycle
        // after the response handshake.
        cmd_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cmd_ready <= 1'b0;
            bus_valid <= 1'b0;
            bus_wen   <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            tcnt_q    <= '0;
`ifdef CSR_MASTER_POLL_EN
            poll_q    <= 1'b0;
            gap_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            cmd_ready <= cmd_ready_d;
            bus_valid <= bus_valid_d;
            bus_wen   <= bus_wen_d;
            bus_addr  <= bus_addr_d;
            bus_wdata <= bus_wdata_d;
            rsp_rdata <= rsp_rdata_d;
            rsp_err   <= rsp_err_d;
            tcnt_q    <= tcnt_d;
`ifdef CSR_MASTER_POLL_EN
            poll_q    <= poll_d;
            gap_q     <= gap_d;
`endif
        end
    end

endmodule

// File: tb/tb_csr_bus_master.sv
// Testbench for csr_bus_master (default build, poll feature disabled).
// Plays host and CSR slave; expected bus requests, response contents, error
// flag and cycle counts come from a transaction-level model of the rules.
module tb_csr_bus_master;

    localparam logic [31:0] BASE = 32'h0000_0010;
    localparam int unsigned TO   = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready, cmd_write, cmd_poll;
    logic [3:0]  cmd_idx;
    logic [31:0] cmd_wdata;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;
    logic        bus_valid, bus_ready, bus_wen;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    int unsigned hs_cnt = 0;
    int unsigned v_cnt = 0;

    csr_bus_master #(
        .CSR_BASE_ADDR (BASE),
        .TIMEOUT_CYCLES(TO),
        .POLL_GAP      (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_idx   (cmd_idx),
        .cmd_wdata (cmd_wdata),
        .cmd_poll  (cmd_poll),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .bus_valid (bus_valid),
        .bus_ready (bus_ready),
        .bus_wen   (bus_wen),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata)
    );

    always #5 clk = ~clk;

    // Bus activity counters: cycles with bus_valid high, and handshakes.
    always @(posedge clk) begin
        if (bus_valid) v_cnt <= v_cnt + 1;
        if (bus_valid && bus_ready) hs_cnt <= hs_cnt + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200000ns");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One complete command. rdly: REQ cycles before the slave raises ready
    // (never raised if a timeout is expected). rspdly: cycles the response is
    // held off, with a junk command pending. rhold: keep bus_ready high after
    // the handshake.
    task automatic run_txn(input bit wr, input logic [3:0] idx, input logic [31:0] wd,
                           input int unsigned rdly, input logic [31:0] rdat,
                           input int unsigned rspdly, input bit rhold);
        logic [31:0] exp_addr, exp_rdata;
        bit          exp_err;
        int unsigned n_req, v0, h0, w;

        exp_addr  = {BASE[31:4], idx};
        exp_err   = (rdly >= TO);
        exp_rdata = (wr || exp_err) ? 32'h0 : rdat;
        n_req     = exp_err ? TO : rdly + 1;

        w = 0;
        while (!cmd_ready && w < 8) begin
            @(negedge clk);
            w++;
        end
        chk("cmd_ready_idle", {31'h0, cmd_ready}, 32'h1);

        v0 = v_cnt;
        h0 = hs_cnt;
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_idx   = idx;
        cmd_wdata = wd;
        cmd_poll  = 1'($urandom);
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_write = 1'($urandom);
        cmd_idx   = 4'($urandom);
        cmd_wdata = $urandom;

        for (int unsigned k = 0; k < n_req; k++) begin
            chk("req_valid", {31'h0, bus_valid}, 32'h1);
            chk("req_addr", bus_addr, exp_addr);
            chk("req_wen", {31'h0, bus_wen}, {31'h0, wr});
            chk("req_wdata", bus_wdata, wd);
            chk("req_cmd_ready", {31'h0, cmd_ready}, 32'h0);
            bus_ready = !exp_err && (k == rdly);
            @(negedge clk);
        end
        bus_ready = rhold;
        chk("valid_dropped", {31'h0, bus_valid}, 32'h0);

        if (!wr && !exp_err) begin
            chk("rcap_no_rsp", {31'h0, rsp_valid}, 32'h0);
            bus_rdata = rdat;
            @(negedge clk);
            bus_rdata = $urandom;
        end

        chk("valid_cycles", v_cnt - v0, n_req);
        chk("handshakes", hs_cnt - h0, exp_err ? 32'h0 : 32'h1);

        for (int unsigned h = 0; h <= rspdly; h++) begin
            chk("rsp_valid", {31'h0, rsp_valid}, 32'h1);
            chk("rsp_rdata", rsp_rdata, exp_rdata);
            chk("rsp_err", {31'h0, rsp_err}, {31'h0, exp_err});
            chk("rsp_cmd_ready", {31'h0, cmd_ready}, 32'h0);
            chk("rsp_bus_valid", {31'h0, bus_valid}, 32'h0);
            if (h == rspdly) begin
                rsp_ready = 1'b1;
            end else begin
                cmd_valid = 1'b1;
                cmd_write = 1'($urandom);
                cmd_idx   = 4'($urandom);
                cmd_wdata = $urandom;
            end
            @(negedge clk);
        end
        rsp_ready = 1'b0;
        cmd_valid = 1'b0;
        bus_ready = 1'b0;
        chk("rsp_done", {31'h0, rsp_valid}, 32'h0);
        chk("rsp_err_clr", {31'h0, rsp_err}, 32'h0);
        chk("next_cmd_ready", {31'h0, cmd_ready}, 32'h1);
        chk("no_early_accept", {31'h0, bus_valid}, 32'h0);
    endtask

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_idx   = 4'h0;
        cmd_wdata = 32'h0;
        cmd_poll  = 1'b0;
        rsp_ready = 1'b0;
        bus_ready = 1'b0;
        bus_rdata = 32'h0;

        // Reset values
        @(negedge clk);
        @(negedge clk);
        chk("rst_cmd_ready", {31'h0, cmd_ready}, 32'h0);
        chk("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        chk("rst_rsp_err", {31'h0, rsp_err}, 32'h0);
        chk("rst_rsp_rdata", rsp_rdata, 32'h0);
        chk("rst_bus_valid", {31'h0, bus_valid}, 32'h0);
        chk("rst_bus_wen", {31'h0, bus_wen}, 32'h0);
        chk("rst_bus_addr", bus_addr, 32'h0);
        chk("rst_bus_wdata", bus_wdata, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", {31'h0, cmd_ready}, 32'h1);

        // Write CONFIG with ready held high: single-cycle bus_valid
        run_txn(1'b1, 4'd1, 32'h1234_5678, 0, 32'hDEAD_BEEF, 0, 1'b1);
        // Read IFMAP_DIMS, fastest path
        run_txn(1'b0, 4'd2, 32'h0, 0, 32'h0010_0020, 0, 1'b0);
        // Ready delayed 5 cycles
        run_txn(1'b0, 4'd4, 32'h5555_AAAA, 5, 32'hCAFE_F00D, 1, 1'b0);
        run_txn(1'b1, 4'd3, 32'h0BAD_C0DE, 5, 32'h0, 0, 1'b0);
        // Timeout: ready never comes
        run_txn(1'b0, 4'd3, 32'h0, 20, 32'h1111_2222, 0, 1'b0);
        run_txn(1'b1, 4'd0, 32'hFFFF_FFFF, 20, 32'h0, 2, 1'b0);
        // Boundary: ready on the last allowed cycle wins over the timeout
        run_txn(1'b0, 4'd1, 32'h0, TO - 1, 32'h7777_0007, 0, 1'b0);
        run_txn(1'b0, 4'd1, 32'h0, TO, 32'h8888_0008, 0, 1'b0);
        // Response back-pressure with a new command pending
        run_txn(1'b1, 4'd0, 32'h0000_0001, 0, 32'h0, 4, 1'b0);
        // Out-of-map index issued unchanged
        run_txn(1'b0, 4'd15, 32'h0, 2, 32'h0, 0, 1'b0);

        // Reset in the middle of a request: no response afterwards
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_idx   = 4'd3;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("mid_req_valid", {31'h0, bus_valid}, 32'h1);
        rst = 1'b1;
        #1;
        chk("mid_rst_bus_valid", {31'h0, bus_valid}, 32'h0);
        chk("mid_rst_cmd_ready", {31'h0, cmd_ready}, 32'h0);
        chk("mid_rst_bus_addr", bus_addr, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        chk("mid_rst_ready_back", {31'h0, cmd_ready}, 32'h1);
        @(negedge clk);
        chk("mid_rst_no_rsp", {31'h0, rsp_valid}, 32'h0);

        // Randomized commands
        for (int i = 0; i < 30; i++) begin
            run_txn(1'($urandom), 4'($urandom), $urandom, $urandom_range(0, 10),
                    $urandom, $urandom_range(0, 3), 1'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
